cy_uart_rx: RTL and testbench
=============================

CY_UART_RX -- requirements
Module: cy_uart_rx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 434, meaning clk cycles per bit (legal range 8..1023).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..9).
REQ-003 SHALL have parameter PARITY, default 0, meaning parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked (1 or 2).
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port data, output, DATA_BITS bits: last received word, LSB received first.
REQ-009 SHALL have port valid, output, 1 bit: one-cycle pulse, frame complete.
REQ-010 SHALL have port parity_err, output, 1 bit: parity mismatch, qualified by valid.
REQ-011 SHALL have port frame_err, output, 1 bit: stop bit sampled 0, qualified by valid.
REQ-012 SHALL have port break_det, output, 1 bit: break frame, qualified by valid.

Function
REQ-013 SHALL pass rx through a 2-flop synchronizer (rx_s); all logic uses rx_s only.
REQ-014 SHALL use a bit counter 0..CLK_DIV-1 with HALF = CLK_DIV/2 (integer division); the counter wraps to 0 after CLK_DIV-1.
REQ-015 SHALL register rx_s at counts HALF-1, HALF and HALF+1, and take each bit value as the 2-of-3 majority of those samples at count HALF+1.
REQ-016 SHALL implement states IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
REQ-017 In IDLE, on rx_s==0 the block SHALL clear the counter and enter START.
REQ-018 In START, a majority-1 decision SHALL return to IDLE (glitch reject, no valid); majority-0 SHALL enter DATA.
REQ-019 DATA SHALL shift DATA_BITS decisions LSB-first into a shift register, then go to PAR if PARITY!=0, else to STOP.
REQ-020 PAR SHALL compare the decided bit against the XOR of the data bits: for odd parity the total count of ones SHALL be odd; for even parity it SHALL be even.
REQ-021 STOP SHALL decide STOP_BITS bits; frame_err SHALL be set if any stop decision is 0.
REQ-022 On the final stop decision, the block SHALL, in the next cycle, load data, assert valid for exactly 1 cycle, and drive parity_err, frame_err and break_det.
REQ-023 If frame_err=0 the block SHALL enter IDLE at the final stop decision, without waiting for the bit end; otherwise it SHALL enter WAIT_HIGH.
REQ-024 WAIT_HIGH SHALL remain until rx_s==1, then go to IDLE.
REQ-025 break_det SHALL be 1 iff all data bits, the parity bit (if present) and the first stop bit decide 0; frame_err SHALL then also be 1.
REQ-026 parity_err SHALL be 0 when PARITY==0.
REQ-027 data, parity_err, frame_err and break_det SHALL hold their values until the next valid.
REQ-028 Undefined state encodings SHALL recover to IDLE the next cycle.
REQ-029 Latency from the first sync'd low to valid SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS-1)*CLK_DIV + HALF + 3 cycles.

Reset
REQ-030 While rst_n==0 at a clk edge, the block SHALL set state to IDLE, clear the counter and sampling registers, and drive valid=0, parity_err=0, frame_err=0, break_det=0, data=0.
REQ-031 The synchronizer flops SHALL reset to 1.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no valid pulse.
REQ-033 Reception SHALL resume on the first low seen after release.

Verification (CLK_DIV=16 unless stated)
REQ-034 Defaults 8N1, send 0xA5 -> one valid pulse, data=0xA5, all error flags 0.
REQ-035 PARITY=2: send 0x03 with parity bit 1 -> valid, parity_err=1; repeat with parity bit 0 -> parity_err=0.
REQ-036 Send 0x5A with stop bit 0, hold rx low 3 bit-times -> valid, frame_err=1, break_det=0, no second frame until rx returns high.
REQ-037 Hold rx low for 12 bit-times -> a single valid with data=0x00, frame_err=1, break_det=1.
REQ-038 Apply a 4-cycle low glitch on idle line -> no valid; a single-cycle high glitch at count HALF inside a data bit -> majority keeps the correct bit.
REQ-039 Back-to-back frames 0x11, 0x22 with no idle gap, plus DATA_BITS=9 and STOP_BITS=2 variants, and rst_n pulsed mid-DATA -> correct words, no valid for the aborted frame.

Source files
------------

// File: rtl/cy_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : cy_uart_rx
// Brief    : UART receiver, 3-sample majority voting, parity/frame/break flags.
// Revision : 1.0 - initial release
// ============================================================================
module cy_uart_rx #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det
);
    localparam int            CW      = $clog2(CLK_DIV);
    localparam int            C_HALF  = CLK_DIV / 2;
    localparam logic [CW-1:0] C_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] C_S0    = CW'(C_HALF - 1);
    localparam logic [CW-1:0] C_S1    = CW'(C_HALF);
    localparam logic [CW-1:0] C_DEC   = CW'(C_HALF + 1);
    localparam logic [3:0]    C_DLAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    C_SLAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PAR       = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  rx_meta_q, rx_s_q;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  smp0_q, smp0_d, smp1_q, smp1_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic [3:0]            bit_q, bit_d;
    logic                  par_q, par_d;
    logic                  stop0_q, stop0_d;
    logic                  frm_q, frm_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  brk_q, brk_d;

    logic w_dec, w_maj, w_frm, w_first, w_ones_odd;

    // Third vote is the live synchronized sample taken at the decision count.
    assign w_dec      = (cnt_q == C_DEC);
    assign w_maj      = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);
    assign w_frm      = frm_q | ~w_maj;
    assign w_first    = (bit_q == 4'd0) ? w_maj : stop0_q;
    assign w_ones_odd = ^{shift_q, par_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == C_LAST) ? '0 : cnt_q + CW'(1);
        smp0_d  = (cnt_q == C_S0) ? rx_s_q : smp0_q;
        smp1_d  = (cnt_q == C_S1) ? rx_s_q : smp1_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        par_d   = par_q;
        stop0_d = stop0_q;
        frm_d   = frm_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        brk_d   = brk_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (w_dec) begin
                    state_d = w_maj ? S_IDLE : S_DATA;
                    bit_d   = 4'd0;
                    frm_d   = 1'b0;
                end
            end
            S_DATA: begin
                if (w_dec) begin
                    shift_d = {w_maj, shift_q[DATA_BITS-1:1]};
                    bit_d   = bit_q + 4'd1;
                    if (bit_q == C_DLAST) begin
                        bit_d   = 4'd0;
                        state_d = (PARITY != 0) ? S_PAR : S_STOP;
                    end
                end
            end
            S_PAR: begin
                if (w_dec) begin
                    par_d   = w_maj;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (w_dec) begin
                    frm_d = w_frm;
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd0) stop0_d = w_maj;
                    // Leave at the decision point so a back-to-back start edge is not missed.
                    if (bit_q == C_SLAST) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        perr_d  = (PARITY == 1) ? ~w_ones_odd :
                                  (PARITY == 2) ?  w_ones_odd : 1'b0;
                        ferr_d  = w_frm;
                        brk_d   = (shift_q == '0) && ((PARITY == 0) || !par_q) && !w_first;
                        state_d = w_frm ? S_WAIT_HIGH : S_IDLE;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            smp0_q    <= 1'b0;
            smp1_q    <= 1'b0;
            shift_q   <= '0;
            bit_q     <= 4'd0;
            par_q     <= 1'b0;
            stop0_q   <= 1'b0;
            frm_q     <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            smp0_q    <= smp0_d;
            smp1_q    <= smp1_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            par_q     <= par_d;
            stop0_q   <= stop0_d;
            frm_q     <= frm_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            brk_q     <= brk_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign break_det  = brk_q;
endmodule
`default_nettype wire

// File: tb/tb_cy_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_cy_uart_rx
// Brief    : Self-checking bench for cy_uart_rx in 8N1, 8E1 and 9O2 setups.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cy_uart_rx;
    localparam int C_DIV = 16;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
        int         cyc;
    } ev_t;

    typedef struct {
        int         d;
        logic [8:0] dat;
        logic       par;
        logic [1:0] stp;
        int         gbit;
        logic [8:0] ed;
        logic       ep;
        logic       ef;
        logic       eb;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       rx_l [3];
    wire  [7:0] data0;
    wire  [7:0] data1;
    wire  [8:0] data2;
    wire  [2:0] valid_w, perr_w, ferr_w, brk_w;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    ev_t  evq0 [$];
    ev_t  evq1 [$];
    ev_t  evq2 [$];
    logic line_q [$];
    vec_t vt [12];

    cy_uart_rx #(.CLK_DIV(C_DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[0]), .data(data0), .valid(valid_w[0]),
        .parity_err(perr_w[0]), .frame_err(ferr_w[0]), .break_det(brk_w[0]));
    cy_uart_rx #(.CLK_DIV(C_DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[1]), .data(data1), .valid(valid_w[1]),
        .parity_err(perr_w[1]), .frame_err(ferr_w[1]), .break_det(brk_w[1]));
    cy_uart_rx #(.CLK_DIV(C_DIV), .DATA_BITS(9), .PARITY(1), .STOP_BITS(2)) u2 (
        .clk(clk), .rst_n(rst_n), .rx(rx_l[2]), .data(data2), .valid(valid_w[2]),
        .parity_err(perr_w[2]), .frame_err(ferr_w[2]), .break_det(brk_w[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk_ev(input logic [8:0] d, input logic p, input logic f, input logic b);
        ev_t e;
        e.data = d; e.perr = p; e.ferr = f; e.brk = b; e.cyc = cyc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (valid_w[0]) evq0.push_back(mk_ev({1'b0, data0}, perr_w[0], ferr_w[0], brk_w[0]));
        if (valid_w[1]) evq1.push_back(mk_ev({1'b0, data1}, perr_w[1], ferr_w[1], brk_w[1]));
        if (valid_w[2]) evq2.push_back(mk_ev(data2, perr_w[2], ferr_w[2], brk_w[2]));
    end

    function automatic int db(input int d); return (d == 2) ? 9 : 8; endfunction
    function automatic int pm(input int d); return (d == 0) ? 0 : (d == 1) ? 2 : 1; endfunction
    function automatic int sb(input int d); return (d == 2) ? 2 : 1; endfunction

    // Frame bits (start + data + parity + stops, minus one) times bit period, plus half bit, plus 3.
    function automatic int lat(input int d);
        return (db(d) + ((pm(d) != 0) ? 1 : 0) + sb(d)) * C_DIV + C_DIV / 2 + 3;
    endfunction

    function automatic logic [8:0] live_data(input int d);
        return (d == 0) ? {1'b0, data0} : (d == 1) ? {1'b0, data1} : data2;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? evq0.size() : (d == 1) ? evq1.size() : evq2.size();
    endfunction

    // Reference: expected flags straight from the frame's line-level bit values.
    function automatic void model(input int d, input logic [8:0] dat, input logic par,
                                  input logic [1:0] stp, output logic [8:0] ed,
                                  output logic ep, output logic ef, output logic eb);
        int ones;
        ones = $countones(dat) + ((pm(d) != 0 && par) ? 1 : 0);
        ed = dat;
        ep = (pm(d) == 1) ? (ones % 2 == 0) : (pm(d) == 2) ? (ones % 2 == 1) : 1'b0;
        ef = !stp[0] || (sb(d) == 2 && !stp[1]);
        eb = (dat == 9'd0) && (pm(d) == 0 || !par) && !stp[0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic build_frame(input int d, input logic [8:0] dat, input logic par, input logic [1:0] stp);
        line_q.push_back(1'b0);
        for (int i = 0; i < db(d); i++) line_q.push_back(dat[i]);
        if (pm(d) != 0) line_q.push_back(par);
        for (int i = 0; i < sb(d); i++) line_q.push_back(stp[i]);
    endtask

    task automatic drive_line(input int d, input int goff, output int start_cyc);
        logic v;
        start_cyc = 0;
        for (int b = 0; b < line_q.size(); b++) begin
            for (int k = 0; k < C_DIV; k++) begin
                @(negedge clk);
                if (b == 0 && k == 0) start_cyc = cyc;
                v = line_q[b];
                if (b * C_DIV + k == goff) v = ~v;
                rx_l[d] = v;
            end
        end
        @(negedge clk);
        rx_l[d] = 1'b1;
        line_q.delete();
    endtask

    task automatic expect_one(input int d, input logic [8:0] ed, input logic ep, input logic ef,
                              input logic eb, input int s_cyc, input string nm);
        ev_t e;
        bit  ok;
        ok = 1'b0;
        e  = mk_ev(9'd0, 1'b0, 1'b0, 1'b0);
        if (d == 0 && evq0.size() > 0) begin e = evq0.pop_front(); ok = 1'b1; end
        if (d == 1 && evq1.size() > 0) begin e = evq1.pop_front(); ok = 1'b1; end
        if (d == 2 && evq2.size() > 0) begin e = evq2.pop_front(); ok = 1'b1; end
        chk({nm, " valid seen"}, 32'(ok), 32'd1);
        if (ok) begin
            chk({nm, " data"}, 32'(e.data), 32'(ed));
            chk({nm, " parity_err"}, 32'(e.perr), 32'(ep));
            chk({nm, " frame_err"}, 32'(e.ferr), 32'(ef));
            chk({nm, " break_det"}, 32'(e.brk), 32'(eb));
            chk({nm, " latency"}, 32'(e.cyc - s_cyc), 32'(lat(d) + 2));
        end
    endtask

    task automatic expect_hold(input int d, input logic [8:0] ed, input logic ep, input logic ef,
                               input logic eb, input string nm);
        chk({nm, " no extra valid"}, 32'(qsize(d)), 32'd0);
        chk({nm, " held data"}, 32'(live_data(d)), 32'(ed));
        chk({nm, " held flags"}, 32'({perr_w[d], ferr_w[d], brk_w[d]}), 32'({ep, ef, eb}));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1);
    end

    initial begin
        int s, s2;
        vt[0]  = '{0, 9'h0A5, 1'b0, 2'b11, 0, 9'h0A5, 1'b0, 1'b0, 1'b0};
        vt[1]  = '{0, 9'h000, 1'b0, 2'b11, 0, 9'h000, 1'b0, 1'b0, 1'b0};
        vt[2]  = '{0, 9'h0FF, 1'b0, 2'b11, 0, 9'h0FF, 1'b0, 1'b0, 1'b0};
        vt[3]  = '{0, 9'h03C, 1'b0, 2'b11, 1, 9'h03C, 1'b0, 1'b0, 1'b0};
        vt[4]  = '{0, 9'h03C, 1'b0, 2'b11, 4, 9'h03C, 1'b0, 1'b0, 1'b0};
        vt[5]  = '{1, 9'h003, 1'b1, 2'b11, 0, 9'h003, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{1, 9'h003, 1'b0, 2'b11, 0, 9'h003, 1'b0, 1'b0, 1'b0};
        vt[7]  = '{1, 9'h080, 1'b1, 2'b11, 0, 9'h080, 1'b0, 1'b0, 1'b0};
        vt[8]  = '{2, 9'h1A5, 1'b0, 2'b11, 0, 9'h1A5, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{2, 9'h1A5, 1'b1, 2'b11, 0, 9'h1A5, 1'b1, 1'b0, 1'b0};
        vt[10] = '{2, 9'h100, 1'b0, 2'b01, 0, 9'h100, 1'b0, 1'b1, 1'b0};
        vt[11] = '{2, 9'h000, 1'b0, 2'b00, 0, 9'h000, 1'b1, 1'b1, 1'b1};

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) rx_l[d] = 1'b1;
        idle(4);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset u%0d data", d), 32'(live_data(d)), 32'd0);
            chk($sformatf("reset u%0d valid+flags", d),
                32'({valid_w[d], perr_w[d], ferr_w[d], brk_w[d]}), 32'd0);
        end
        rst_n = 1'b1;
        idle(4);

        for (int i = 0; i < 12; i++) begin
            build_frame(vt[i].d, vt[i].dat, vt[i].par, vt[i].stp);
            drive_line(vt[i].d, (vt[i].gbit == 0) ? -1 : vt[i].gbit * C_DIV + C_DIV / 2 + 1, s);
            idle(2 * C_DIV);
            expect_one(vt[i].d, vt[i].ed, vt[i].ep, vt[i].ef, vt[i].eb, s, $sformatf("vec%0d", i));
            expect_hold(vt[i].d, vt[i].ed, vt[i].ep, vt[i].ef, vt[i].eb, $sformatf("vec%0d", i));
        end

        // Short low pulse on an idle line must be rejected as a false start.
        @(negedge clk); rx_l[0] = 1'b0;
        idle(4);
        rx_l[0] = 1'b1;
        idle(3 * C_DIV);
        chk("idle glitch no valid", 32'(qsize(0)), 32'd0);

        build_frame(0, 9'h011, 1'b0, 2'b11);
        build_frame(0, 9'h022, 1'b0, 2'b11);
        drive_line(0, -1, s);
        idle(2 * C_DIV);
        expect_one(0, 9'h011, 1'b0, 1'b0, 1'b0, s, "b2b first");
        expect_one(0, 9'h022, 1'b0, 1'b0, 1'b0, s + 10 * C_DIV, "b2b second");
        expect_hold(0, 9'h022, 1'b0, 1'b0, 1'b0, "b2b");

        // Reset pulse in the middle of the data bits aborts the frame.
        line_q.push_back(1'b0);
        for (int i = 0; i < 3; i++) line_q.push_back(1'b1);
        drive_line(0, -1, s);
        rst_n = 1'b0;
        idle(3);
        chk("midreset data cleared", 32'(live_data(0)), 32'd0);
        chk("midreset flags cleared", 32'({valid_w[0], perr_w[0], ferr_w[0], brk_w[0]}), 32'd0);
        rst_n = 1'b1;
        idle(3 * C_DIV);
        chk("midreset no valid", 32'(qsize(0)), 32'd0);
        build_frame(0, 9'h096, 1'b0, 2'b11);
        drive_line(0, -1, s);
        idle(2 * C_DIV);
        expect_one(0, 9'h096, 1'b0, 1'b0, 1'b0, s, "after reset");

        // Stop bit low, line held low 3 bit-times total.
        build_frame(0, 9'h05A, 1'b0, 2'b10);
        line_q.push_back(1'b0);
        line_q.push_back(1'b0);
        drive_line(0, -1, s);
        idle(2 * C_DIV);
        expect_one(0, 9'h05A, 1'b0, 1'b1, 1'b0, s, "frame err");
        expect_hold(0, 9'h05A, 1'b0, 1'b1, 1'b0, "frame err");

        for (int i = 0; i < 12; i++) line_q.push_back(1'b0);
        drive_line(0, -1, s);
        idle(2 * C_DIV);
        expect_one(0, 9'h000, 1'b0, 1'b1, 1'b1, s, "break");
        expect_hold(0, 9'h000, 1'b0, 1'b1, 1'b1, "break");

        for (int it = 0; it < 24; it++) begin
            int         d, goff;
            logic [8:0] dat, ed;
            logic       par, ep, ef, eb;
            logic [1:0] stp;
            d      = int'($urandom_range(0, 2));
            dat    = 9'($urandom) & ((db(d) == 9) ? 9'h1FF : 9'h0FF);
            par    = 1'($urandom_range(0, 1));
            stp[0] = ($urandom_range(0, 7) != 0);
            stp[1] = ($urandom_range(0, 7) != 0);
            goff   = ($urandom_range(0, 3) == 0) ?
                     int'($urandom_range(1, db(d))) * C_DIV + C_DIV / 2 + 1 : -1;
            model(d, dat, par, stp, ed, ep, ef, eb);
            build_frame(d, dat, par, stp);
            drive_line(d, goff, s2);
            idle(2 * C_DIV);
            expect_one(d, ed, ep, ef, eb, s2, $sformatf("rand%0d", it));
            expect_hold(d, ed, ep, ef, eb, $sformatf("rand%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
